// File: rtl/apb_timer_if.sv
// -----------------------------------------------------------------------------
// apb_timer_if -- APB bus bundle for the apb_timer block.
//   master modport : drives PSEL, PENABLE, PADDR, PWRITE, PWDATA;
//                    receives PRDATA, PREADY, PSLVERR
//   slave modport  : the mirror image, used by apb_timer
// -----------------------------------------------------------------------------
interface apb_timer_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer.sv
// -----------------------------------------------------------------------------
// apb_timer -- APB-programmable down-counting timer with prescaler,
// auto-reload / one-shot modes and a level interrupt.
//   PCLK   : clock, all state changes on its rising edge
//   PRESET : asynchronous active-high reset
//   apb    : APB slave port (every transfer gets exactly one wait state)
//   IRQ    : INTSTAT[0] AND CTRL.IRQEN
// Register map (PADDR[11:0]): 0x00 CTRL {DIV[15:8], RELOAD[2], IRQEN[1],
// EN[0]}, 0x04 LOAD, 0x08 VALUE, 0x0C INTSTAT[0] (write-1-to-clear).
// -----------------------------------------------------------------------------
module apb_timer #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_timer_if.slave      apb,
    output logic            IRQ
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [11:0] ADDR_CTRL    = 12'h000;
    localparam logic [11:0] ADDR_LOAD    = 12'h004;
    localparam logic [11:0] ADDR_VALUE   = 12'h008;
    localparam logic [11:0] ADDR_INTSTAT = 12'h00C;

    state_e                 state_q, state_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATAWIDTH-1:0]   prdata_q, prdata_d;
    logic                   en_q, en_d;
    logic                   irqen_q, irqen_d;
    logic                   reload_q, reload_d;
    logic [7:0]             div_q, div_d;
    logic [DATAWIDTH-1:0]   load_q, load_d;
    logic [DATAWIDTH-1:0]   value_q, value_d;
    logic                   intstat_q, intstat_d;
    logic [7:0]             presc_q, presc_d;
    logic                   irq_q, irq_d;

    logic [ADDRWIDTH-1:0]   paddr_s;
    logic [11:0]            addr_s;
    logic                   unused_addr_s;
    logic                   access_s;
    logic                   commit_s;
    logic                   err_s;
    logic                   wr_s;
    logic                   ctrl_wr_s;
    logic                   load_wr_s;
    logic                   value_wr_s;
    logic                   intstat_wr_s;
    logic                   tick_s;
    logic                   terminal_s;
    logic [DATAWIDTH-1:0]   rd_data_s;

    assign paddr_s       = apb.PADDR;
    assign addr_s        = paddr_s[11:0];
    assign unused_addr_s = ^paddr_s[ADDRWIDTH-1:12];
    assign access_s      = apb.PSEL && apb.PENABLE;
    assign err_s         = (addr_s > ADDR_INTSTAT) || (addr_s[1:0] != 2'b00);
    assign wr_s          = commit_s && apb.PWRITE && !err_s;
    assign ctrl_wr_s     = wr_s && (addr_s == ADDR_CTRL);
    assign load_wr_s     = wr_s && (addr_s == ADDR_LOAD);
    assign value_wr_s    = wr_s && (addr_s == ADDR_VALUE);
    assign intstat_wr_s  = wr_s && (addr_s == ADDR_INTSTAT);

    // Transfer FSM state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer FSM next state; dropping PSEL/PENABLE during WAIT abandons the transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) state_d = ST_WAIT;
                else          state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (access_s) state_d = ST_RESP;
                else          state_d = ST_IDLE;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer FSM outputs; commit_s marks the WAIT->RESP edge where reads and writes land
    always_comb begin
        commit_s = 1'b0;
        pready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                commit_s = 1'b0;
                pready_d = access_s ? 1'b0 : 1'b0;
            end
            ST_WAIT: begin
                commit_s = access_s;
                pready_d = access_s;
            end
            ST_RESP: begin
                commit_s = 1'b0;
                pready_d = 1'b0;
            end
            default: begin
                commit_s = 1'b0;
                pready_d = 1'b0;
            end
        endcase
    end

    // Read data mux; unused bits read as zero
    always_comb begin
        rd_data_s = {DATAWIDTH{1'b0}};
        case (addr_s)
            ADDR_CTRL:    rd_data_s = {{(DATAWIDTH-16){1'b0}}, div_q, 5'b00000,
                                       reload_q, irqen_q, en_q};
            ADDR_LOAD:    rd_data_s = load_q;
            ADDR_VALUE:   rd_data_s = value_q;
            ADDR_INTSTAT: rd_data_s = {{(DATAWIDTH-1){1'b0}}, intstat_q};
            default:      rd_data_s = {DATAWIDTH{1'b0}};
        endcase
    end

    // Timer datapath and register next-state; software writes take priority over timer events
    always_comb begin
        en_d      = en_q;
        irqen_d   = irqen_q;
        reload_d  = reload_q;
        div_d     = div_q;
        load_d    = load_q;
        value_d   = value_q;
        intstat_d = intstat_q;
        presc_d   = presc_q;

        // >= rather than == so that lowering DIV below the running count ticks at once
        tick_s     = en_q && (presc_q >= div_q);
        terminal_s = tick_s && (value_q == {DATAWIDTH{1'b0}}) && !value_wr_s;

        if (!en_q || tick_s) begin
            presc_d = 8'd0;
        end else begin
            presc_d = presc_q + 8'd1;
        end
        // A CTRL write that starts (0->1) or stops the timer restarts the prescaler
        if (ctrl_wr_s && (!en_q || !apb.PWDATA[0])) begin
            presc_d = 8'd0;
        end else begin
            presc_d = presc_d;
        end

        if (value_wr_s) begin
            value_d = apb.PWDATA;
        end else if (tick_s) begin
            if (value_q != {DATAWIDTH{1'b0}}) begin
                value_d = value_q - DATAWIDTH'(1);
            end else if (reload_q) begin
                value_d = load_q;
            end else begin
                value_d = {DATAWIDTH{1'b0}};
            end
        end else begin
            value_d = value_q;
        end

        if (terminal_s && !reload_q) begin
            en_d = 1'b0;
        end else begin
            en_d = en_q;
        end
        if (ctrl_wr_s) begin
            en_d     = apb.PWDATA[0];
            irqen_d  = apb.PWDATA[1];
            reload_d = apb.PWDATA[2];
            div_d    = apb.PWDATA[15:8];
        end else begin
            div_d    = div_q;
        end

        if (load_wr_s) begin
            load_d = apb.PWDATA;
        end else begin
            load_d = load_q;
        end

        if (terminal_s) begin
            intstat_d = 1'b1;
        end else if (intstat_wr_s && apb.PWDATA[0]) begin
            intstat_d = 1'b0;
        end else begin
            intstat_d = intstat_q;
        end
    end

    // Bus response next-state: PRDATA is zero for writes and errors, held between transfers
    always_comb begin
        prdata_d  = prdata_q;
        pslverr_d = commit_s && err_s;
        if (commit_s) begin
            if (!apb.PWRITE && !err_s) prdata_d = rd_data_s;
            else                       prdata_d = {DATAWIDTH{1'b0}};
        end else begin
            prdata_d = prdata_q;
        end
        irq_d = intstat_d && irqen_d;
    end

    // Register bank, timer state and registered bus outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= {DATAWIDTH{1'b0}};
            en_q      <= 1'b0;
            irqen_q   <= 1'b0;
            reload_q  <= 1'b0;
            div_q     <= 8'd0;
            load_q    <= {DATAWIDTH{1'b0}};
            value_q   <= {DATAWIDTH{1'b0}};
            intstat_q <= 1'b0;
            presc_q   <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            en_q      <= en_d;
            irqen_q   <= irqen_d;
            reload_q  <= reload_d;
            div_q     <= div_d;
            load_q    <= load_d;
            value_q   <= value_d;
            intstat_q <= intstat_d;
            presc_q   <= presc_d;
            irq_q     <= irq_d;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign IRQ         = irq_q;
endmodule

// File: tb/tb_apb_timer.sv
// -----------------------------------------------------------------------------
// tb_apb_timer -- directed, table-driven bench for apb_timer: a vector table of
// single APB transfers with hand-computed responses, followed by hand-written
// cycle-exact sequences for timer periods, one-shot, write/tick collisions and
// reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_apb_timer;
    logic PCLK;
    logic PRESET;
    logic IRQ;
    int   n_checks;
    int   n_pass;
    int   cyc;

    apb_timer_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

    apb_timer #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus.slave),
        .IRQ    (IRQ)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // free-running cycle stamp used to measure timer periods
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = addr; bus.PWRITE = wr; bus.PWDATA = wdata;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        waits = 0;
        @(posedge PCLK); #1;
        while (!bus.PREADY && waits < 8) begin
            waits++;
            @(posedge PCLK); #1;
        end
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        if (!bus.PREADY) begin
            n_checks++;
            $display("FAIL pready_timeout: addr 0x%04h got no PREADY, expected PREADY=1", addr);
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input string name);
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, addr, data, rd, er, w);
        check({name, "_err"}, {31'd0, er}, 32'd0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b0, addr, 32'd0, rd, er, w);
        check(name, rd, exp);
    endtask

    task automatic wait_irq(output int stamp, input string name);
        int n;
        n = 0;
        while (!IRQ && n < 64) begin
            @(posedge PCLK); #1;
            n++;
        end
        stamp = cyc;
        check({name, "_irq_seen"}, {31'd0, IRQ}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        int          t0, t1, t2;

        n_checks = 0; n_pass = 0; cyc = 0;
        vecs[0]  = '{1'b0, 16'h0000, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b0, 16'h0004, 32'h0,         32'h0,         1'b0};
        vecs[2]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{1'b0, 16'h000C, 32'h0,         32'h0,         1'b0};
        vecs[4]  = '{1'b1, 16'h0004, 32'hDEADBEEF,  32'h0,         1'b0};
        vecs[5]  = '{1'b0, 16'h0004, 32'h0,         32'hDEADBEEF,  1'b0};
        vecs[6]  = '{1'b0, 16'h1004, 32'h0,         32'hDEADBEEF,  1'b0};
        vecs[7]  = '{1'b1, 16'h0000, 32'hFFFFFFF6,  32'h0,         1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 32'h0,         32'h0000FF06,  1'b0};
        vecs[9]  = '{1'b1, 16'h0008, 32'h12345678,  32'h0,         1'b0};
        vecs[10] = '{1'b0, 16'h0008, 32'h0,         32'h12345678,  1'b0};
        vecs[11] = '{1'b1, 16'h0006, 32'hFFFFFFFF,  32'h0,         1'b1};
        vecs[12] = '{1'b0, 16'h0010, 32'h0,         32'h0,         1'b1};
        vecs[13] = '{1'b0, 16'h000E, 32'h0,         32'h0,         1'b1};
        vecs[14] = '{1'b1, 16'h0010, 32'hFFFFFFFF,  32'h0,         1'b1};
        vecs[15] = '{1'b0, 16'h0004, 32'h0,         32'hDEADBEEF,  1'b0};
        vecs[16] = '{1'b0, 16'h0008, 32'h0,         32'h12345678,  1'b0};
        vecs[17] = '{1'b0, 16'h0000, 32'h0,         32'h0000FF06,  1'b0};
        vecs[18] = '{1'b1, 16'h000C, 32'h00000001,  32'h0,         1'b0};
        vecs[19] = '{1'b0, 16'h000C, 32'h0,         32'h0,         1'b0};
        vecs[20] = '{1'b1, 16'h0000, 32'h0,         32'h0,         1'b0};
        vecs[21] = '{1'b0, 16'h0000, 32'h0,         32'h0,         1'b0};

        PRESET = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = 16'h0;
        bus.PWRITE = 1'b0; bus.PWDATA = 32'h0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready",  {31'd0, bus.PREADY},  32'd0);
        check("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        check("rst_prdata",  bus.PRDATA,           32'd0);
        check("rst_irq",     {31'd0, IRQ},         32'd0);
        PRESET = 1'b0;

        // table of single transfers: data, error flag and exactly one wait state
        for (int i = 0; i < NVEC; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), 32'(w), 32'd1);
        end

        // auto-reload: LOAD=5, VALUE=5, DIV=0 -> IRQ every 6 cycles
        do_write(16'h0004, 32'd5, "ar_load");
        do_write(16'h0008, 32'd5, "ar_value");
        do_write(16'h0000, 32'h7, "ar_ctrl");
        t0 = cyc;
        wait_irq(t1, "ar_first");
        check("ar_first_delay", 32'(t1 - t0), 32'd6);
        do_write(16'h000C, 32'd1, "ar_w1c");
        check("ar_irq_cleared", {31'd0, IRQ}, 32'd0);
        wait_irq(t2, "ar_second");
        check("ar_period", 32'(t2 - t1), 32'd6);
        // reloaded to 5 at the IRQ edge, then 3 more ticks before the read samples
        do_read(16'h0008, 32'd2, "ar_value_after_reload");
        do_write(16'h0000, 32'h0, "ar_stop");
        do_write(16'h000C, 32'd1, "ar_clear");
        check("ar_irq_low", {31'd0, IRQ}, 32'd0);

        // one-shot: VALUE=3, DIV=2 -> terminal after 4 ticks of 3 cycles
        do_write(16'h0008, 32'd3, "os_value");
        do_write(16'h0000, 32'h0203, "os_ctrl");
        t0 = cyc;
        wait_irq(t1, "os");
        check("os_delay", 32'(t1 - t0), 32'd12);
        do_read(16'h0000, 32'h0202, "os_ctrl_en_cleared");
        do_read(16'h0008, 32'd0, "os_value_zero");
        do_read(16'h000C, 32'd1, "os_intstat");
        do_write(16'h000C, 32'd1, "os_w1c");
        do_write(16'h0000, 32'h0, "os_stop");
        do_read(16'h000C, 32'd0, "os_intstat_cleared");

        // W1C landing on the terminal tick: set wins
        do_write(16'h0004, 32'h100, "c1_load");
        do_write(16'h0008, 32'd3, "c1_value");
        do_write(16'h0000, 32'h5, "c1_ctrl");
        do_write(16'h000C, 32'd1, "c1_w1c_on_terminal");
        do_read(16'h000C, 32'd1, "c1_intstat_set_wins");
        do_write(16'h0000, 32'h0, "c1_stop");
        do_write(16'h000C, 32'd1, "c1_clear");

        // VALUE write landing on a terminal tick (DIV=255, tick 256 cycles after start)
        do_write(16'h0008, 32'd0, "c2_value0");
        do_write(16'h0000, 32'h0000FF01, "c2_ctrl");
        repeat (252) @(posedge PCLK);
        #1;
        do_write(16'h0008, 32'h10, "c2_value_on_tick");
        do_read(16'h0008, 32'h10, "c2_value_write_wins");
        do_read(16'h0000, 32'h0000FF01, "c2_no_oneshot_stop");
        do_read(16'h000C, 32'd0, "c2_no_terminal");
        do_write(16'h0000, 32'h0, "c2_stop");

        // reset during the WAIT state of a LOAD write
        do_write(16'h0004, 32'h55, "rs_load_pre");
        do_write(16'h0008, 32'h99, "rs_value_pre");
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 16'h0004;
        bus.PWRITE = 1'b1; bus.PWDATA = 32'h77;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("rs_in_wait", {31'd0, bus.PREADY}, 32'd0);
        #1 PRESET = 1'b1;
        #1;
        check("rs_pready", {31'd0, bus.PREADY}, 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        do_read(16'h0004, 32'd0, "rs_load_cleared");
        do_read(16'h0008, 32'd0, "rs_value_cleared");
        apb_xfer(1'b1, 16'h0004, 32'hA5, rd, er, w);
        check("rs_next_write_waits", 32'(w), 32'd1);
        do_read(16'h0004, 32'hA5, "rs_next_write_data");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
